// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle fetch/decode/execute control FSM (FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT).
// Define ILLEGAL_TRAP_EN to send undefined opcodes (0xA-0xE) to FAULT instead of executing them as NOPs.
module cpu_sequencer #(
  parameter int RET_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      ir,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             trap,
  output logic [RET_W-1:0] retired_count
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam int              TW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   WAIT_LOAD = TW'(MEM_TIMEOUT - 1);
  localparam logic [3:0]      OP_ADDI   = 4'h5;
  localparam logic [3:0]      OP_LW     = 4'h6;
  localparam logic [3:0]      OP_SW     = 4'h7;
  localparam logic [3:0]      OP_BEQ    = 4'h8;
  localparam logic [3:0]      OP_JMP    = 4'h9;
  localparam logic [3:0]      OP_HALT   = 4'hF;

  state_t        state, state_nxt;
  logic          run;
  logic          waiting, ack, expired, retire;
  logic [TW-1:0] wait_cnt;
  logic [3:0]    op;

  // run holds off imem_req for the first cycle after reset release
  assign op      = ir[31:28];
  assign waiting = run && ((state == S_FETCH) || (state == S_MEM));
  assign ack     = (state == S_FETCH) ? imem_ack : dmem_ack;
  assign expired = waiting && !ack && (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      run           <= 1'b0;
      ir            <= '0;
      wait_cnt      <= WAIT_LOAD;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if ((state == S_FETCH) && waiting && imem_ack)
        ir <= imem_rdata;
      // down-counter: reaches zero on the MEM_TIMEOUT-th wait cycle
      if (!waiting)
        wait_cnt <= WAIT_LOAD;
      else if (!ack && (wait_cnt != '0))
        wait_cnt <= wait_cnt - TW'(1);
      if (retire)
        retired_count <= retired_count + RET_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = run;
        if (waiting && imem_ack) state_nxt = S_DECODE;
        else if (expired)        state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        alu_op      = op;
        alu_src_imm = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
        if (op <= OP_ADDI) begin
          state_nxt = S_WB;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_nxt = S_MEM;
        end else if (op == OP_BEQ) begin
          pc_load   = branch_taken;
          pc_inc    = !branch_taken;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (op == OP_JMP) begin
          pc_load   = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (op == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = S_HALT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_FAULT;
`else
          pc_inc    = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ack) begin
          if (op == OP_SW) begin
            pc_inc    = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (expired) begin
          state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op == OP_LW);
        pc_inc    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        trap   = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: strobe events are scoreboarded against expected
// events queued when each instruction is driven; timing, timeout, trap and reset checked inline.
module tb_cpu_sequencer;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          branch_taken = 1'b0;
  logic          imem_req, dmem_req, dmem_we;
  logic [31:0]   ir;
  logic [3:0]    alu_op;
  logic          alu_src_imm, reg_write, wb_sel, pc_inc, pc_load, halted, trap;
  logic [RW-1:0] retired_count;

  cpu_sequencer #(.RET_W(RW), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir(ir), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .wb_sel(wb_sel),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .trap(trap),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rw; logic wbs; logic inc; logic load; } ev_t;
  localparam logic [3:0] EV_WB_ALU = 4'b1010;
  localparam logic [3:0] EV_WB_LD  = 4'b1110;
  localparam logic [3:0] EV_INC    = 4'b0010;
  localparam logic [3:0] EV_LOAD   = 4'b0001;

  ev_t           exp_q[$];
  ev_t           obs_q[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            vectors = 0;
  int            errors = 0;
  logic [RW-1:0] exp_cnt = '0;

  // monitor: one event per cycle with any PC/regfile strobe
  always @(negedge clk) begin
    cyc++;
    if (rst_n && (reg_write || pc_inc || pc_load)) begin
      obs_q.push_back(ev_t'({reg_write, wb_sel, pc_inc, pc_load}));
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; imem_rdata = '0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); exp_cnt = '0;
  endtask

  // drives one instruction through fetch/exec/mem, returning what it saw
  task automatic drive_instr(input logic [31:0] w, input int dwait, input logic bt,
                             output int ack_cyc, output int dreq, output logic we_seen,
                             output logic [3:0] aop, output logic aimm, output bit tmo);
    int n;
    tmo = 0; dreq = 0; we_seen = 1'b0; n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    if (!imem_req) tmo = 1;
    imem_rdata = w; imem_ack = 1'b1; ack_cyc = cyc + 1;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    tick();
    branch_taken = bt;
    #1;
    aop = alu_op; aimm = alu_src_imm;
    tick();
    branch_taken = 1'b0;
    n = 0;
    while (dmem_req && n < 40) begin
      dreq++; we_seen |= dmem_we; dmem_ack = (n == dwait);
      tick();
      dmem_ack = 1'b0; n++;
    end
    n = 0;
    while (!imem_req && !halted && n < 4) begin tick(); n++; end
    if (n >= 4) tmo = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({imem_req, dmem_req, reg_write, pc_inc, pc_load, halted, trap} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000000",
                         {imem_req, dmem_req, reg_write, pc_inc, pc_load, halted, trap});
    end
    vectors++;
    if (ir !== 32'h0 || retired_count !== '0) begin
      errors++; $display("FAIL reset_ir_count: got ir=%h cnt=%0d want 0/0", ir, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL req_before_edge: got %b want 0", imem_req); end
    tick();
    vectors++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL req_after_edge: got %b want 1", imem_req); end
  endtask

  task automatic test_alu();
    int a, d; logic we, imm; logic [3:0] aop; bit tmo; ev_t e, o; int c;
    do_reset();
    exp_q.push_back(ev_t'(EV_WB_ALU)); exp_cnt++;
    drive_instr(mk(4'h0, 4'd1, 4'd3, 4'd5, 16'h0), 0, 1'b0, a, d, we, aop, imm, tmo);
    vectors++;
    if (aop !== 4'h0 || imm !== 1'b0 || tmo) begin
      errors++; $display("FAIL add_exec: got op=%h imm=%b tmo=%0d want 0/0/0", aop, imm, tmo);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL add_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e || c != a + 3) begin
          errors++; $display("FAIL add_event: got %b at +%0d want %b at +3", o, c - a, e);
        end
      end
    end
    vectors++;
    if (retired_count !== exp_cnt) begin
      errors++; $display("FAIL add_count: got %0d want %0d", retired_count, exp_cnt);
    end
    exp_q.push_back(ev_t'(EV_WB_ALU)); exp_cnt++;
    drive_instr(mk(4'h5, 4'd2, 4'd1, 4'd0, 16'h1234), 0, 1'b0, a, d, we, aop, imm, tmo);
    vectors++;
    if (aop !== 4'h5 || imm !== 1'b1 || d != 0) begin
      errors++; $display("FAIL addi_exec: got op=%h imm=%b dreq=%0d want 5/1/0", aop, imm, d);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL addi_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e) begin errors++; $display("FAIL addi_event: got %b want %b", o, e); end
      end
    end
  endtask

  task automatic test_load_store();
    int a, d; logic we, imm; logic [3:0] aop; bit tmo; ev_t e, o; int c;
    exp_q.push_back(ev_t'(EV_WB_LD)); exp_cnt++;
    drive_instr(mk(4'h6, 4'd4, 4'd2, 4'd0, 16'h0010), 3, 1'b0, a, d, we, aop, imm, tmo);
    vectors++;
    if (d != 4 || we !== 1'b0 || imm !== 1'b1) begin
      errors++; $display("FAIL lw_mem: got dreq=%0d we=%b imm=%b want 4/0/1", d, we, imm);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL lw_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e || c != a + 7) begin
          errors++; $display("FAIL lw_event: got %b at +%0d want %b at +7", o, c - a, e);
        end
      end
    end
    exp_q.push_back(ev_t'(EV_INC)); exp_cnt++;
    drive_instr(mk(4'h7, 4'd0, 4'd2, 4'd4, 16'h0011), 0, 1'b0, a, d, we, aop, imm, tmo);
    vectors++;
    if (d != 1 || we !== 1'b1) begin
      errors++; $display("FAIL sw_mem: got dreq=%0d we=%b want 1/1", d, we);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL sw_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e || c != a + 3) begin
          errors++; $display("FAIL sw_event: got %b at +%0d want %b at +3", o, c - a, e);
        end
      end
    end
    vectors++;
    if (retired_count !== exp_cnt) begin
      errors++; $display("FAIL ldst_count: got %0d want %0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_branch();
    int a, d; logic we, imm; logic [3:0] aop; bit tmo; ev_t e, o; int c;
    exp_q.push_back(ev_t'(EV_LOAD)); exp_cnt++;
    drive_instr(mk(4'h8, 4'd0, 4'd1, 4'd1, 16'h0040), 0, 1'b1, a, d, we, aop, imm, tmo);
    exp_q.push_back(ev_t'(EV_INC)); exp_cnt++;
    drive_instr(mk(4'h8, 4'd0, 4'd1, 4'd2, 16'h0040), 0, 1'b0, a, d, we, aop, imm, tmo);
    exp_q.push_back(ev_t'(EV_LOAD)); exp_cnt++;
    drive_instr(mk(4'h9, 4'd0, 4'd0, 4'd0, 16'h0100), 0, 1'b0, a, d, we, aop, imm, tmo);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL branch_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e) begin errors++; $display("FAIL branch_event: got %b want %b", o, e); end
      end
    end
    vectors++;
    if (obs_q.size() != 0 || retired_count !== exp_cnt) begin
      errors++; $display("FAIL branch_count: got extra=%0d cnt=%0d want 0/%0d",
                         obs_q.size(), retired_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int reqs;
    do_reset();
    tick();
    reqs = 0;
    while (imem_req && reqs < 40) begin reqs++; tick(); end
    vectors++;
    if (reqs != 16 || halted !== 1'b1 || trap !== 1'b1) begin
      errors++; $display("FAIL timeout_fault: got reqs=%0d halted=%b trap=%b want 16/1/1",
                         reqs, halted, trap);
    end
    do_reset();
    tick();
    for (int i = 0; i < 15; i++) tick();
    imem_rdata = mk(4'h2, 4'd1, 4'd2, 4'd3, 16'h0); imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    vectors++;
    if (halted !== 1'b0 || trap !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL ack_at_limit: got halted=%b trap=%b req=%b want 0/0/0",
                         halted, trap, imem_req);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (retired_count !== RW'(1) || imem_req !== 1'b1) begin
      errors++; $display("FAIL ack_at_limit_retire: got cnt=%0d req=%b want 1/1",
                         retired_count, imem_req);
    end
  endtask

  task automatic test_illegal_halt();
    int a, d; logic we, imm; logic [3:0] aop; bit tmo; ev_t e, o; int c; bit req_seen;
    do_reset();
`ifdef ILLEGAL_TRAP_EN
    drive_instr(mk(4'hA, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1'b0, a, d, we, aop, imm, tmo);
    vectors++;
    if (trap !== 1'b1 || halted !== 1'b1 || retired_count !== exp_cnt || obs_q.size() != 0) begin
      errors++; $display("FAIL illegal_trap: got trap=%b halted=%b cnt=%0d ev=%0d want 1/1/0/0",
                         trap, halted, retired_count, obs_q.size());
    end
    do_reset();
`else
    exp_q.push_back(ev_t'(EV_INC)); exp_cnt++;
    drive_instr(mk(4'hA, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1'b0, a, d, we, aop, imm, tmo);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL illegal_nop: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e) begin errors++; $display("FAIL illegal_nop: got %b want %b", o, e); end
      end
    end
    vectors++;
    if (trap !== 1'b0 || retired_count !== exp_cnt) begin
      errors++; $display("FAIL illegal_nop_count: got trap=%b cnt=%0d want 0/%0d",
                         trap, retired_count, exp_cnt);
    end
`endif
    exp_cnt++;
    drive_instr(mk(4'hF, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1'b0, a, d, we, aop, imm, tmo);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin req_seen |= imem_req; tick(); end
    vectors++;
    if (halted !== 1'b1 || trap !== 1'b0 || req_seen || retired_count !== exp_cnt
        || obs_q.size() != 0) begin
      errors++; $display("FAIL halt: got halted=%b trap=%b req=%0d cnt=%0d ev=%0d want 1/0/0/%0d/0",
                         halted, trap, req_seen, retired_count, obs_q.size(), exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int a, d; logic we, imm; logic [3:0] aop, op; bit tmo; ev_t e, o; int c;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      op = 4'($urandom_range(0, 5));
      exp_q.push_back(ev_t'(EV_WB_ALU)); exp_cnt++;
      drive_instr(mk(op, 4'(k), 4'(k + 1), 4'(k + 2), 16'(k)), 0, 1'b0, a, d, we, aop, imm, tmo);
      vectors++;
      if (aop !== op || tmo) begin
        errors++; $display("FAIL b2b_aluop: got %h tmo=%0d want %h/0", aop, tmo, op);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_event: got none want %b", e); end
      else begin
        o = obs_q.pop_front(); c = obs_cyc.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_event: got %b want %b", o, e); end
      end
    end
    vectors++;
    if (retired_count !== exp_cnt) begin
      errors++; $display("FAIL count_wrap: got %0d want %0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    int a, d; logic we, imm; logic [3:0] aop; bit tmo; logic [31:0] w;
    do_reset();
    drive_instr(mk(4'h1, 4'd1, 4'd2, 4'd3, 16'h0), 0, 1'b0, a, d, we, aop, imm, tmo);
    w = mk(4'h6, 4'd7, 4'd1, 4'd0, 16'h0055);
    imem_rdata = w; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    tick();
    tick();
    vectors++;
    if (dmem_req !== 1'b1 || ir !== w || retired_count !== RW'(1)) begin
      errors++; $display("FAIL mid_mem: got req=%b ir=%h cnt=%0d want 1/%h/1",
                         dmem_req, ir, retired_count, w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || ir !== 32'h0 || retired_count !== '0) begin
      errors++; $display("FAIL async_reset: got req=%b ir=%h cnt=%0d want 0/0/0",
                         dmem_req, ir, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL refetch: got imem_req=%b dmem_req=%b want 1/0", imem_req, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_illegal_halt();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
